// File: rtl/shift_buffer_arbiter.sv
// shift_buffer_arbiter
//   Round-robin arbiter and burst sequencer that shares the shift buffer's
//   write port among NUM_REQ requesters. A winner is granted an uninterrupted
//   burst of BEATS words. When the burst ends, the block waits for the shift
//   buffer to report a full vector and then reports which requester owns it.
//   A downstream credit (vec_ready_i) gates the start of each new burst.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   req_valid_i       : per-requester word valid
//   req_data_i        : requester k drives bits [k*DATA_W +: DATA_W]
//   req_ready_o       : per-requester word accept (equals grant_o)
//   vec_ready_i       : downstream can take one more vector
//   sb_data_o         : word to the shift buffer
//   sb_wr_en_o        : write strobe to the shift buffer
//   sb_data_valid_i   : shift buffer reports a completed vector
//   grant_o           : one-hot current owner, zero when idle
//   owner_o           : index of the requester that owns the completed vector
//   owner_valid_o     : one-cycle pulse qualifying owner_o
//   busy_o            : a burst is running or awaiting its vector
//   timeout_err_o     : sticky flag, the shift buffer never reported a vector
module shift_buffer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int BEATS   = 8,
  parameter int TIMEOUT = 15,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      vec_ready_i,
  output logic [DATA_W-1:0]         sb_data_o,
  output logic                      sb_wr_en_o,
  input  logic                      sb_data_valid_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [ID_W-1:0]           owner_o,
  output logic                      owner_valid_o,
  output logic                      busy_o,
  output logic                      timeout_err_o
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    WAIT_VALID
  } state_t;

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     gnt_idx;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [WAIT_W-1:0]   wait_cnt;

  logic                arb_found;
  logic [ID_W-1:0]     arb_idx;
  logic [ID_W-1:0]     cand;
  logic                handshake;
  logic [DATA_W-1:0]   gnt_data;

  // Round-robin search: walk the requesters starting at rr_ptr and wrapping
  // upward, and take the first one that is asking. The first hit wins, so the
  // lowest index at or above the pointer has priority.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!arb_found && req_valid_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // grant_o is only non-zero during a burst, so it doubles as the ready
  // vector; the registered index selects the owner's data lane.
  assign req_ready_o = grant_o;
  assign handshake   = |(req_valid_i & grant_o);
  assign gnt_data    = req_data_i[int'(gnt_idx)*DATA_W +: DATA_W];
  assign busy_o      = (state != IDLE);

  // Main sequencer. IDLE arbitrates when downstream has credit, BURST moves
  // exactly BEATS words from the single owner (stalling on its valid), and
  // WAIT_VALID holds until the shift buffer reports the vector or the wait
  // budget runs out. A timeout is sticky and only reset clears it.
  // sb_wr_en_o and owner_valid_o default low so they are single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      gnt_idx       <= '0;
      beat_cnt      <= '0;
      wait_cnt      <= '0;
      grant_o       <= '0;
      sb_data_o     <= '0;
      sb_wr_en_o    <= 1'b0;
      owner_o       <= '0;
      owner_valid_o <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      sb_wr_en_o    <= 1'b0;
      owner_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (vec_ready_i && arb_found) begin
            grant_o <= NUM_REQ'(1) << arb_idx;
            gnt_idx <= arb_idx;
            state   <= BURST;
          end
        end
        BURST: begin
          if (handshake) begin
            sb_data_o  <= gnt_data;
            sb_wr_en_o <= 1'b1;
            if (beat_cnt == BEAT_W'(BEATS - 1)) begin
              owner_o  <= gnt_idx;
              rr_ptr   <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
              beat_cnt <= '0;
              grant_o  <= '0;
              state    <= WAIT_VALID;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        WAIT_VALID: begin
          // A valid seen in the last allowed cycle still wins over the timeout.
          // The timeout fires in the cycle where the count would reach TIMEOUT.
          if (sb_data_valid_i) begin
            owner_valid_o <= 1'b1;
            wait_cnt      <= '0;
            state         <= IDLE;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            timeout_err_o <= 1'b1;
            wait_cnt      <= '0;
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_buffer_arbiter.sv
// tb_shift_buffer_arbiter
//   Self-checking bench for shift_buffer_arbiter with the default parameters
//   (4 requesters, 32-bit words, 8-beat bursts, timeout of 15 cycles).
//   Expected grants come from a round-robin pointer kept by the bench, the
//   expected write stream is the word list handed to the owner, and the shift
//   buffer's vector-ready response is driven directly by the bench.
module tb_shift_buffer_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int BEATS   = 8;
  localparam int TIMEOUT = 15;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      vec_ready;
  logic [DATA_W-1:0]         sb_data;
  logic                      sb_wr_en;
  logic                      sb_data_valid;
  logic [NUM_REQ-1:0]        grant;
  logic [1:0]                owner;
  logic                      owner_valid;
  logic                      busy;
  logic                      timeout_err;

  int checks;
  int errors;
  int model_ptr;
  bit model_err;
  logic [DATA_W-1:0] burst_words [BEATS];

  shift_buffer_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W),
    .BEATS  (BEATS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready),
    .vec_ready_i    (vec_ready),
    .sb_data_o      (sb_data),
    .sb_wr_en_o     (sb_wr_en),
    .sb_data_valid_i(sb_data_valid),
    .grant_o        (grant),
    .owner_o        (owner),
    .owner_valid_o  (owner_valid),
    .busy_o         (busy),
    .timeout_err_o  (timeout_err)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int k, input logic [DATA_W-1:0] w);
    req_data[k*DATA_W +: DATA_W] = w;
  endtask

  // Round-robin rule: first requesting index at or above the pointer, wrapping.
  function automatic int pick_winner(input logic [NUM_REQ-1:0] mask);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mask[(model_ptr + i) % NUM_REQ]) return (model_ptr + i) % NUM_REQ;
    end
    return 0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  sb_data, 0);
    check({tag, "_wren"},  sb_wr_en, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_owner"}, owner, 0);
    check({tag, "_ownv"},  owner_valid, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_terr"},  timeout_err, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    req_valid = '0;
    vec_ready = 1'b0;
    sb_data_valid = 1'b0;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    model_ptr = 0;
    model_err = 1'b0;
  endtask

  // Cycles spent in IDLE with no grant possible (no credit or no requests).
  task automatic idle_cycles(input int n, input bit no_credit);
    for (int c = 0; c < n; c++) begin
      if (no_credit) begin
        req_valid = 4'($urandom_range(0, 15));
        vec_ready = 1'b0;
      end else begin
        req_valid = '0;
        vec_ready = 1'b1;
      end
      sb_data_valid = 1'($urandom_range(0, 1));
      tick();
      check("idle_grant", grant, 0);
      check("idle_busy", busy, 0);
      check("idle_ownv", owner_valid, 0);
      check("idle_terr", timeout_err, model_err);
    end
  endtask

  // One complete transaction starting in an IDLE cycle: arbitration, the
  // burst of burst_words (with an optional bubble before beat bubble_at),
  // then the wait for the vector. valid_delay < 0 means the shift buffer
  // never answers. abort_after >= 0 stops after that many handshakes.
  task automatic run_burst(input logic [NUM_REQ-1:0] mask, input int bubble_at,
                           input int bubble_len, input int valid_delay,
                           input int abort_after);
    int w;
    int b;
    int bub;
    bit v;
    w = pick_winner(mask);
    req_valid = mask;
    vec_ready = 1'b1;
    sb_data_valid = 1'($urandom_range(0, 1));
    for (int k = 0; k < NUM_REQ; k++) set_word(k, $urandom);
    tick();
    check("arb_grant", grant, 64'd1 << w);
    check("arb_ready", req_ready, 64'd1 << w);
    check("arb_busy", busy, 1);
    check("arb_wren", sb_wr_en, 0);
    check("arb_ownv", owner_valid, 0);

    b = 0;
    bub = bubble_len;
    while (b < BEATS && !(abort_after >= 0 && b >= abort_after)) begin
      v = !(b == bubble_at && bub > 0);
      if (!v) bub--;
      req_valid = mask;
      req_valid[w] = v;
      for (int k = 0; k < NUM_REQ; k++) if (k != w) set_word(k, $urandom);
      set_word(w, burst_words[b]);
      vec_ready = 1'($urandom_range(0, 1));
      sb_data_valid = 1'($urandom_range(0, 1));
      tick();
      check("beat_wren", sb_wr_en, v);
      if (v) begin
        check("beat_data", sb_data, burst_words[b]);
        b++;
      end else begin
        check("beat_hold", sb_data, burst_words[b-1]);
      end
      if (b < BEATS) begin
        check("beat_grant", grant, 64'd1 << w);
        check("beat_ready", req_ready, 64'd1 << w);
        check("beat_busy", busy, 1);
      end else begin
        check("wait_grant", grant, 0);
        check("wait_ready", req_ready, 0);
        check("wait_busy", busy, 1);
        check("wait_owner", owner, w);
      end
    end
    if (b < BEATS) return;

    model_ptr = (w + 1) % NUM_REQ;
    req_valid = mask;
    if (valid_delay < 0) begin
      for (int c = 1; c <= TIMEOUT; c++) begin
        sb_data_valid = 1'b0;
        tick();
        check("to_ownv", owner_valid, 0);
        if (c < TIMEOUT) begin
          check("to_terr_early", timeout_err, model_err);
          check("to_busy", busy, 1);
        end else begin
          model_err = 1'b1;
          check("to_terr", timeout_err, 1);
          check("to_idle", busy, 0);
          check("to_owner", owner, w);
        end
      end
    end else begin
      for (int c = 0; c < valid_delay; c++) begin
        sb_data_valid = 1'b0;
        tick();
        check("wv_ownv", owner_valid, 0);
        check("wv_busy", busy, 1);
        check("wv_terr", timeout_err, model_err);
      end
      sb_data_valid = 1'b1;
      tick();
      check("own_valid", owner_valid, 1);
      check("own_id", owner, w);
      check("own_idle", busy, 0);
      check("own_terr", timeout_err, model_err);
      sb_data_valid = 1'b0;
    end
  endtask

  task automatic random_words();
    for (int i = 0; i < BEATS; i++) burst_words[i] = $urandom;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_ptr = 0;
    model_err = 1'b0;
    rst = 1'b0;
    req_valid = '0;
    req_data = '0;
    vec_ready = 1'b0;
    sb_data_valid = 1'b0;

    do_reset();

    // Single requester, words 10..17.
    $display("[TB] single requester");
    for (int i = 0; i < BEATS; i++) burst_words[i] = 32'(10 + i);
    run_burst(4'b0001, -1, 0, 1, -1);

    // Round robin from a fresh pointer: expect 0,1,2,3,0.
    $display("[TB] round robin");
    do_reset();
    for (int n = 0; n < 5; n++) begin
      random_words();
      run_burst(4'b1111, -1, 0, $urandom_range(0, 3), -1);
    end

    // Bubble of two cycles after beat 3 from requester 1.
    $display("[TB] bubbles");
    for (int i = 0; i < BEATS; i++) burst_words[i] = 32'(20 + i);
    run_burst(4'b0010, 3, 2, 2, -1);

    // No downstream credit for 20 cycles, then a grant the next cycle.
    $display("[TB] credit");
    for (int c = 0; c < 20; c++) begin
      req_valid = 4'b1111;
      vec_ready = 1'b0;
      tick();
      check("credit_grant", grant, 0);
      check("credit_busy", busy, 0);
      check("credit_ready", req_ready, 0);
    end
    random_words();
    run_burst(4'b1111, -1, 0, 0, -1);

    // Shift buffer never answers; a following burst still works.
    $display("[TB] timeout");
    random_words();
    run_burst(4'b1111, -1, 0, -1, -1);
    random_words();
    run_burst(4'b0101, -1, 0, TIMEOUT - 1, -1);

    // Randomized transactions with bubbles, late valids and idle gaps.
    $display("[TB] random");
    for (int n = 0; n < 30; n++) begin
      int bat;
      int dly;
      random_words();
      bat = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, BEATS - 1));
      dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT - 1));
      run_burst(4'($urandom_range(1, 15)), bat, $urandom_range(1, 3), dly, -1);
      idle_cycles($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset after three beats of requester 2, then requester 0 wins.
    $display("[TB] reset mid-burst");
    random_words();
    run_burst(4'b0100, -1, 0, 0, 3);
    do_reset();
    random_words();
    run_burst(4'b1111, -1, 0, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
